// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write path: register number and data
// widths, register count, default starvation limit and the hard-wired zero register.
package regfile_pkg;
    localparam int AW             = 5;
    localparam int DW             = 32;
    localparam int NREG           = 2 ** AW;
    localparam int STARVE_MAX_DEF = 4;
    localparam logic [AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/dec_5to32.sv
// Enabled 5-to-32 one-hot decoder: drives a single bit for sel when en is high.
module dec_5to32
    import regfile_pkg::*;
(
    input  logic [AW-1:0]   sel,
    input  logic            en,
    output logic [NREG-1:0] dout
);

    // One-hot expansion of sel, all zeros when disabled.
    always_comb begin
        dout = '0;
        if (en) begin
            dout[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/wb_grant_sel.sv
// Writeback grant selector: picks one winner among valid requesters.
// A requester whose age has reached the starvation limit beats plain
// fixed priority; ties at either level go to the lowest index.
module wb_grant_sel #(
    parameter int NREQ  = 3,
    parameter int AGE_W = 3
) (
    input  logic [NREQ-1:0]       valid,
    input  logic [NREQ*AGE_W-1:0] age,
    input  logic [AGE_W-1:0]      starve_max,
    output logic [NREQ-1:0]       grant
);

    logic starved;
    logic picked;

    // Starved requesters first, then plain lowest-index priority.
    always_comb begin
        grant   = '0;
        starved = 1'b0;
        picked  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!starved && valid[i] && (age[i*AGE_W +: AGE_W] == starve_max)) begin
                grant[i] = 1'b1;
                starved  = 1'b1;
            end
        end
        if (!starved) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!picked && valid[i]) begin
                    grant[i] = 1'b1;
                    picked   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: shares the single write port between NREQ
// requesters with fixed priority plus starvation relief, registers the winning
// (wn, wd, we) triple and tracks outstanding writes per register for hazard checks.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ       = 3,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_rn,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               rsv_valid,
    input  logic [AW-1:0]      rsv_rn,
    output logic [AW-1:0]      wn,
    output logic [DW-1:0]      wd,
    output logic               we,
    output logic [NREG-1:0]    busy,
    output logic               sb_err
);

    localparam int AGE_W = $clog2(STARVE_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_MAX);

    logic [AGE_W-1:0]      age [NREQ];
    logic [NREQ*AGE_W-1:0] age_flat;
    logic [NREQ-1:0]       grant;
    logic                  xfer;
    logic                  xfer_wr;
    logic [AW-1:0]         xfer_rn;
    logic [DW-1:0]         xfer_data;
    logic                  rsv_en;
    logic [NREG-1:0]       set_vec;
    logic [NREG-1:0]       clr_vec;
    logic [1:0]            cnt     [NREG];
    logic [1:0]            cnt_nxt [NREG];
    logic                  err_nxt;

    // Saturating age increment, holding at the starvation limit.
    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
        return (a >= AGE_MAX) ? AGE_MAX : a + 1'b1;
    endfunction

    // Flatten the age counters for the grant selector.
    always_comb begin
        age_flat = '0;
        for (int i = 0; i < NREQ; i++) begin
            age_flat[i*AGE_W +: AGE_W] = age[i];
        end
    end

    wb_grant_sel #(
        .NREQ  (NREQ),
        .AGE_W (AGE_W)
    ) u_grant_sel (
        .valid      (req_valid),
        .age        (age_flat),
        .starve_max (AGE_MAX),
        .grant      (grant)
    );

    // No grants while reset is held, even with requests pending.
    assign req_ready = grant & {NREQ{clrn}};
    assign xfer      = |req_ready;

    // Route the winning requester's register number and data.
    always_comb begin
        xfer_rn   = '0;
        xfer_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                xfer_rn   = req_rn[i*AW +: AW];
                xfer_data = req_data[i*DW +: DW];
            end
        end
    end

    // r0 is hard-wired: writes to it are accepted but never reach the port or scoreboard.
    assign xfer_wr = xfer && (xfer_rn != REG_ZERO);
    assign rsv_en  = rsv_valid && (rsv_rn != REG_ZERO);

    dec_5to32 u_set_dec (
        .sel  (rsv_rn),
        .en   (rsv_en),
        .dout (set_vec)
    );

    dec_5to32 u_clr_dec (
        .sel  (xfer_rn),
        .en   (xfer_wr),
        .dout (clr_vec)
    );

    // Per-requester age: count lost arbitrations, clear on grant or idle.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < NREQ; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] || !req_valid[i]) begin
                    age[i] <= '0;
                end else begin
                    age[i] <= age_inc(age[i]);
                end
            end
        end
    end

    // Registered write port; wn/wd hold when nothing is written.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            we <= 1'b0;
            wn <= '0;
            wd <= '0;
        end else begin
            we <= xfer_wr;
            if (xfer_wr) begin
                wn <= xfer_rn;
                wd <= xfer_data;
            end
        end
    end

    // Next scoreboard counts: reserve increments, retire decrements, both cancel.
    always_comb begin
        err_nxt = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt[r] = cnt[r];
            case ({set_vec[r], clr_vec[r]})
                2'b10: begin
                    if (cnt[r] == 2'd3) err_nxt = 1'b1;
                    else                cnt_nxt[r] = cnt[r] + 2'd1;
                end
                2'b01: begin
                    if (cnt[r] == 2'd0) err_nxt = 1'b1;
                    else                cnt_nxt[r] = cnt[r] - 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Scoreboard counters and the sticky error flag.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= 2'd0;
            end
            sb_err <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            sb_err <= sb_err | err_nxt;
        end
    end

    // A register is busy while any write to it is outstanding.
    always_comb begin
        busy = '0;
        for (int r = 0; r < NREG; r++) begin
            busy[r] = (cnt[r] != 2'd0);
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change on the falling edge,
// outputs are sampled on the falling edge (or 1 time unit after an input change).
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        clrn;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_rn;
    logic [95:0] req_data;
    logic        rsv_valid;
    logic [4:0]  rsv_rn;
    logic [4:0]  wn;
    logic [31:0] wd;
    logic        we;
    logic [31:0] busy;
    logic        sb_err;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb_arbiter #(
        .NREQ       (3),
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rn    (req_rn),
        .req_data  (req_data),
        .rsv_valid (rsv_valid),
        .rsv_rn    (rsv_rn),
        .wn        (wn),
        .wd        (wd),
        .we        (we),
        .busy      (busy),
        .sb_err    (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int idx, input logic [4:0] rn, input logic [31:0] data);
        req_rn[idx*5 +: 5]    = rn;
        req_data[idx*32 +: 32] = data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn      = 1'b0;
        req_valid = 3'b000;
        rsv_valid = 1'b0;
        rsv_rn    = 5'd0;
        req_rn    = '0;
        req_data  = '0;
        @(negedge clk);
        clrn = 1'b1;
    endtask

    task automatic test_reset();
        clrn      = 1'b1;
        rsv_valid = 1'b0;
        rsv_rn    = 5'd0;
        req_valid = 3'b111;
        set_req(0, 5'd1, 32'h1111_0000);
        set_req(1, 5'd2, 32'h2222_0000);
        set_req(2, 5'd3, 32'h3333_0000);
        #1 clrn = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL rst_ready: got %b want 000", req_ready); end
        n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", we); end
        n_cmp++; if (busy !== 32'h0) begin n_err++; $display("FAIL rst_busy: got %h want 0", busy); end
        n_cmp++; if (sb_err !== 1'b0) begin n_err++; $display("FAIL rst_sb_err: got %b want 0", sb_err); end
        n_cmp++; if ({wn, wd} !== 37'h0) begin n_err++; $display("FAIL rst_wn_wd: got %h/%h want 0/0", wn, wd); end
        clrn = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL rel_ready0: got %b want 001", req_ready); end
        @(negedge clk);
        n_cmp++; if ({we, wn, wd} !== {1'b1, 5'd1, 32'h1111_0000}) begin n_err++; $display("FAIL rel_wr0: got we=%b wn=%0d wd=%h want 1/1/11110000", we, wn, wd); end
        req_valid = 3'b110;
        #1;
        n_cmp++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL rel_ready1: got %b want 010", req_ready); end
        @(negedge clk);
        n_cmp++; if ({we, wn, wd} !== {1'b1, 5'd2, 32'h2222_0000}) begin n_err++; $display("FAIL rel_wr1: got we=%b wn=%0d wd=%h want 1/2/22220000", we, wn, wd); end
        req_valid = 3'b100;
        #1;
        n_cmp++; if (req_ready !== 3'b100) begin n_err++; $display("FAIL rel_ready2: got %b want 100", req_ready); end
        @(negedge clk);
        n_cmp++; if ({we, wn, wd} !== {1'b1, 5'd3, 32'h3333_0000}) begin n_err++; $display("FAIL rel_wr2: got we=%b wn=%0d wd=%h want 1/3/33330000", we, wn, wd); end
        req_valid = 3'b000;
        #1;
        n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL rel_idle_ready: got %b want 000", req_ready); end
        @(negedge clk);
        n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL rel_we_drop: got %b want 0", we); end
        // registers 1..3 were retired without ever being reserved
        n_cmp++; if (sb_err !== 1'b1) begin n_err++; $display("FAIL retire_unreserved_err: got %b want 1", sb_err); end
    endtask

    task automatic test_starvation();
        logic [2:0] exp_st [7];
        exp_st = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b001, 3'b001};
        do_reset();
        set_req(0, 5'd0, 32'hA0A0_A0A0);
        set_req(2, 5'd0, 32'hC2C2_C2C2);
        req_valid = 3'b101;
        for (int k = 0; k < 7; k++) begin
            #1;
            n_cmp++; if (req_ready !== exp_st[k]) begin n_err++; $display("FAIL starve_cycle%0d: got %b want %b", k, req_ready, exp_st[k]); end
            @(negedge clk);
        end
        req_valid = 3'b000;
    endtask

    task automatic test_write_port();
        do_reset();
        rsv_valid = 1'b1;
        rsv_rn    = 5'd5;
        @(negedge clk);
        rsv_valid = 1'b0;
        n_cmp++; if (busy[5] !== 1'b1) begin n_err++; $display("FAIL wp_rsv_busy5: got %b want 1", busy[5]); end
        set_req(1, 5'd5, 32'hDEAD_BEEF);
        req_valid = 3'b010;
        #1;
        n_cmp++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL wp_ready: got %b want 010", req_ready); end
        @(negedge clk);
        req_valid = 3'b000;
        n_cmp++; if ({we, wn, wd} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL wp_write: got we=%b wn=%0d wd=%h want 1/5/deadbeef", we, wn, wd); end
        n_cmp++; if (busy[5] !== 1'b0) begin n_err++; $display("FAIL wp_busy5_clear: got %b want 0", busy[5]); end
        @(negedge clk);
        n_cmp++; if ({we, wn, wd} !== {1'b0, 5'd5, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL wp_hold: got we=%b wn=%0d wd=%h want 0/5/deadbeef", we, wn, wd); end
        n_cmp++; if (sb_err !== 1'b0) begin n_err++; $display("FAIL wp_sb_err: got %b want 0", sb_err); end
    endtask

    task automatic test_scoreboard_sat();
        do_reset();
        rsv_valid = 1'b1;
        rsv_rn    = 5'd7;
        repeat (3) @(negedge clk);
        rsv_valid = 1'b0;
        n_cmp++; if (busy[7] !== 1'b1) begin n_err++; $display("FAIL sb_busy7_after3: got %b want 1", busy[7]); end
        set_req(0, 5'd7, 32'h0000_0007);
        req_valid = 3'b001;
        @(negedge clk);
        req_valid = 3'b000;
        n_cmp++; if (busy[7] !== 1'b1) begin n_err++; $display("FAIL sb_busy7_cnt2: got %b want 1", busy[7]); end
        rsv_valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (sb_err !== 1'b0) begin n_err++; $display("FAIL sb_err_at3: got %b want 0", sb_err); end
        @(negedge clk);
        rsv_valid = 1'b0;
        n_cmp++; if (sb_err !== 1'b1) begin n_err++; $display("FAIL sb_err_overflow: got %b want 1", sb_err); end
        n_cmp++; if (busy[7] !== 1'b1) begin n_err++; $display("FAIL sb_busy7_sat: got %b want 1", busy[7]); end
        req_valid = 3'b001;
        @(negedge clk);
        n_cmp++; if (busy[7] !== 1'b1) begin n_err++; $display("FAIL sb_retire1_busy: got %b want 1", busy[7]); end
        @(negedge clk);
        n_cmp++; if (busy[7] !== 1'b1) begin n_err++; $display("FAIL sb_retire2_busy: got %b want 1", busy[7]); end
        @(negedge clk);
        req_valid = 3'b000;
        n_cmp++; if (busy[7] !== 1'b0) begin n_err++; $display("FAIL sb_retire3_busy: got %b want 0", busy[7]); end
    endtask

    task automatic test_rsv_retire_same();
        do_reset();
        n_cmp++; if (sb_err !== 1'b0) begin n_err++; $display("FAIL same_sb_err_reset: got %b want 0", sb_err); end
        rsv_valid = 1'b1;
        rsv_rn    = 5'd9;
        @(negedge clk);
        set_req(0, 5'd9, 32'h9999_9999);
        req_valid = 3'b001;
        @(negedge clk);
        rsv_valid = 1'b0;
        req_valid = 3'b000;
        n_cmp++; if (busy[9] !== 1'b1) begin n_err++; $display("FAIL same_busy9: got %b want 1", busy[9]); end
        n_cmp++; if (sb_err !== 1'b0) begin n_err++; $display("FAIL same_sb_err: got %b want 0", sb_err); end
        n_cmp++; if ({we, wn} !== {1'b1, 5'd9}) begin n_err++; $display("FAIL same_write: got we=%b wn=%0d want 1/9", we, wn); end
        req_valid = 3'b001;
        @(negedge clk);
        req_valid = 3'b000;
        n_cmp++; if (busy[9] !== 1'b0) begin n_err++; $display("FAIL same_final_busy9: got %b want 0", busy[9]); end
        n_cmp++; if (sb_err !== 1'b0) begin n_err++; $display("FAIL same_final_sb_err: got %b want 0", sb_err); end
    endtask

    task automatic test_r0_and_async_reset();
        do_reset();
        set_req(2, 5'd0, 32'h1234_5678);
        req_valid = 3'b100;
        rsv_valid = 1'b1;
        rsv_rn    = 5'd0;
        #1;
        n_cmp++; if (req_ready !== 3'b100) begin n_err++; $display("FAIL r0_ready: got %b want 100", req_ready); end
        @(negedge clk);
        req_valid = 3'b000;
        rsv_valid = 1'b0;
        n_cmp++; if ({we, wn, wd} !== {1'b0, 5'd0, 32'h0}) begin n_err++; $display("FAIL r0_no_write: got we=%b wn=%0d wd=%h want 0/0/0", we, wn, wd); end
        n_cmp++; if ({busy, sb_err} !== 33'h0) begin n_err++; $display("FAIL r0_scoreboard: got busy=%h err=%b want 0/0", busy, sb_err); end
        rsv_valid = 1'b1;
        rsv_rn    = 5'd4;
        @(negedge clk);
        rsv_rn = 5'd6;
        set_req(0, 5'd4, 32'hCAFE_F00D);
        req_valid = 3'b001;
        @(negedge clk);
        rsv_valid = 1'b0;
        req_valid = 3'b000;
        n_cmp++; if ({we, wn, busy[6]} !== {1'b1, 5'd4, 1'b1}) begin n_err++; $display("FAIL ar_pre: got we=%b wn=%0d busy6=%b want 1/4/1", we, wn, busy[6]); end
        #2 clrn = 1'b0;
        #1;
        n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL ar_we: got %b want 0", we); end
        n_cmp++; if (busy !== 32'h0) begin n_err++; $display("FAIL ar_busy: got %h want 0", busy); end
        n_cmp++; if ({wn, wd} !== 37'h0) begin n_err++; $display("FAIL ar_wn_wd: got %h/%h want 0/0", wn, wd); end
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        n_cmp++; if ({we, sb_err} !== 2'b00) begin n_err++; $display("FAIL ar_after: got we=%b err=%b want 0/0", we, sb_err); end
    endtask

    initial begin
        clrn      = 1'b1;
        req_valid = 3'b000;
        req_rn    = '0;
        req_data  = '0;
        rsv_valid = 1'b0;
        rsv_rn    = 5'd0;
        test_reset();
        test_starvation();
        test_write_port();
        test_scoreboard_sat();
        test_rsv_retire_same();
        test_r0_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
